// File: rtl/dsp_mac_sequencer.sv
// Streaming MAC sequencer for one DSP48A1 slice: accepts operand pairs, steers OPMODE/CEP
// through a tag pipe matching the slice latency, and captures the dot product from P.
module dsp_mac_sequencer #(
  parameter int MLAT = 3,
  parameter int LW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LW-1:0]       len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [17:0]  in_a,
  input  logic signed [17:0]  in_b,
  output logic signed [17:0]  dsp_a,
  output logic signed [17:0]  dsp_b,
  output logic                dsp_cea,
  output logic                dsp_cem,
  output logic [7:0]          dsp_opmode,
  output logic                dsp_cep,
  output logic                dsp_rstp,
  input  logic signed [47:0]  dsp_p,
  output logic signed [47:0]  res_data,
  output logic                res_valid,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic [7:0] OPM_LOAD = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P

  state_t            state, state_nxt;
  logic [LW-1:0]     cnt, cnt_nxt;
  logic              first_q, first_nxt;
  logic              acc;
  logic              capture;
  logic              job_empty;

  // Tag pipe: bit s-1 of the registered vectors holds stage s; *_all adds stage 0 (this cycle's accept)
  logic [MLAT:0]     vld_p, first_p, last_p;
  logic [MLAT+1:0]   vld_all, first_all, last_all;

  logic [7:0]        opmode_p;
  logic              cep_p;
  logic signed [47:0] res_p;

  assign in_ready   = (state == ACCUM);
  assign acc        = in_valid & in_ready;
  assign dsp_a      = in_a;
  assign dsp_b      = in_b;
  assign dsp_cea    = acc;
  assign dsp_cem    = 1'b1;
  assign dsp_rstp   = rst;
  assign dsp_opmode = opmode_p;
  assign dsp_cep    = cep_p;
  assign res_data   = res_p;
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  assign vld_all   = {vld_p,   acc};
  assign first_all = {first_p, acc & first_q};
  assign last_all  = {last_p,  acc & (cnt == LW'(1))};

  assign capture   = (state == DRAIN) && vld_all[MLAT+1] && last_all[MLAT+1];
  assign job_empty = (state == IDLE) && start && (len == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    first_nxt = first_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt = ACCUM;
            cnt_nxt   = len;
            first_nxt = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        if (acc) begin
          cnt_nxt   = cnt - LW'(1);
          first_nxt = 1'b0;
          if (cnt == LW'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (capture) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      first_q <= 1'b0;
      vld_p   <= '0;
      first_p <= '0;
      last_p  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      first_q <= first_nxt;
      vld_p   <= vld_all[MLAT:0];
      first_p <= first_all[MLAT:0];
      last_p  <= last_all[MLAT:0];
    end
  end

  // Stage MLAT-1 / MLAT outputs: registered so the slice sees them one and zero cycles before P update
  always_ff @(posedge clk) begin
    if (rst) begin
      opmode_p <= '0;
      cep_p    <= 1'b0;
    end else begin
      if (vld_all[MLAT-2]) opmode_p <= first_all[MLAT-2] ? OPM_LOAD : OPM_ACC;
      cep_p <= vld_all[MLAT-1];
    end
  end

  // Result capture: P of the last tag, or zero for an empty job
  always_ff @(posedge clk) begin
    if (rst)            res_p <= '0;
    else if (job_empty) res_p <= '0;
    else if (capture)   res_p <= dsp_p;
  end

endmodule
